knn_dist_sorter: RTL

//  Datapath receiver for the KNN control FSM's (test point, data point) stream.
//  - Computes the squared Euclidean distance for every beat.
//  - Keeps an insertion-sorted list of the K nearest data points (distance + index).
//  - Raises KNN_VALID_O once all NUM_PTS points are ranked; results read through an index port.

---
 rtl/knn_if.sv | 25 ++
 rtl/knn_dist_sorter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_if.sv
// Stream and result-port bundle between the KNN control FSM and the distance sorter.
// The master drives point pairs and the rank select; the slave returns the selected rank.
interface knn_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int DIST_W = 34
);
  logic              i_knn_start;
  logic [DATA_W-1:0] i_knn_test_pt;
  logic [DATA_W-1:0] i_knn_data_pt;
  logic [IDX_W-1:0]  i_res_sel;
  logic [DIST_W-1:0] o_res_dist;
  logic [IDX_W-1:0]  o_res_idx;
  logic              o_knn_valid;

  modport master (
    output i_knn_start, i_knn_test_pt, i_knn_data_pt, i_res_sel,
    input  o_res_dist, o_res_idx, o_knn_valid
  );

  modport slave (
    input  i_knn_start, i_knn_test_pt, i_knn_data_pt, i_res_sel,
    output o_res_dist, o_res_idx, o_knn_valid
  );
endinterface

// File: rtl/knn_dist_sorter.sv
// Squared-distance pipeline feeding an insertion-sorted list of the K nearest points.
// A four-state FSM frames each run of NUM_PTS beats and flags when the list is final.
module knn_dist_sorter #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16,
  parameter int NUM_PTS = 8,
  parameter int IDX_W   = 3,
  parameter int K       = 4,
  parameter int DIST_W  = 34
) (
  input  logic  i_clk,
  input  logic  i_rst,
  knn_if.slave  knn
);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RANK_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic               r_drain, w_drain_nxt;
  logic               r_valid;
  logic               w_accept, w_abort, w_reinit, w_ins;
  logic [IDX_W-1:0]   w_beat_idx;

  logic [COORD_W-1:0] w_xt, w_yt, w_xd, w_yd, w_dx, w_dy;
  logic               r_s1_vld, r_s2_vld;
  logic [COORD_W-1:0] r_s1_dx, r_s1_dy;
  logic [IDX_W-1:0]   r_s1_idx, r_s2_idx;
  logic [DIST_W-1:0]  r_s2_dist, w_d;

  logic [DIST_W-1:0]  r_dist [K];
  logic [IDX_W-1:0]   r_lidx [K];
  logic [DIST_W-1:0]  w_dist_nxt [K];
  logic [IDX_W-1:0]   w_lidx_nxt [K];
  logic [DIST_W-1:0]  w_up_dist [K];
  logic [IDX_W-1:0]   w_up_idx [K];
  logic [K-1:0]       w_lt, w_prev_lt;
  logic [RANK_W-1:0]  w_rank;

  // State register and run counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_drain    <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_drain    <= w_drain_nxt;
      r_valid    <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic; any START=0 before DONE aborts the run
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_drain_nxt    = r_drain;
    w_accept       = 1'b0;
    w_abort        = 1'b0;
    w_reinit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (knn.i_knn_start) begin
          w_reinit       = 1'b1;
          w_accept       = 1'b1;
          w_beat_cnt_nxt = CNT_W'(1);
          w_drain_nxt    = 1'b0;
          w_state_nxt    = (NUM_PTS == 1) ? ST_DRAIN : ST_ACCUM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (!knn.i_knn_start) begin
          w_abort        = 1'b1;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else if (r_beat_cnt < CNT_W'(NUM_PTS)) begin
          w_accept       = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          if (r_beat_cnt == CNT_W'(NUM_PTS - 1)) begin
            w_drain_nxt = 1'b0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_drain_nxt = 1'b0;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!knn.i_knn_start) begin
          w_abort        = 1'b1;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else if (r_drain) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_drain_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        if (!knn.i_knn_start) begin
          w_beat_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_beat_cnt_nxt = '0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign w_beat_idx = (r_state == ST_IDLE) ? '0 : r_beat_cnt[IDX_W-1:0];
  assign w_xt = knn.i_knn_test_pt[DATA_W-1:COORD_W];
  assign w_yt = knn.i_knn_test_pt[COORD_W-1:0];
  assign w_xd = knn.i_knn_data_pt[DATA_W-1:COORD_W];
  assign w_yd = knn.i_knn_data_pt[COORD_W-1:0];
  assign w_dx = (w_xt >= w_xd) ? (w_xt - w_xd) : (w_xd - w_xt);
  assign w_dy = (w_yt >= w_yd) ? (w_yt - w_yd) : (w_yd - w_yt);
  assign w_d  = (DIST_W'(r_s1_dx) * DIST_W'(r_s1_dx)) + (DIST_W'(r_s1_dy) * DIST_W'(r_s1_dy));

  // S1/S2 pipeline registers; abort kills any beat still in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_dx   <= '0;
      r_s1_dy   <= '0;
      r_s1_idx  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_dist <= '0;
      r_s2_idx  <= '0;
    end else begin
      r_s1_vld  <= w_accept;
      r_s1_dx   <= w_dx;
      r_s1_dy   <= w_dy;
      r_s1_idx  <= w_beat_idx;
      r_s2_vld  <= r_s1_vld && !w_abort;
      r_s2_dist <= w_d;
      r_s2_idx  <= r_s1_idx;
    end
  end

  assign w_ins = r_s2_vld && !w_abort;

  for (genvar g = 0; g < K; g++) begin : g_rank
    assign w_lt[g] = (r_s2_dist < r_dist[g]);
    if (g == 0) begin : g_top
      assign w_up_dist[g] = r_dist[g];
      assign w_up_idx[g]  = r_lidx[g];
    end else begin : g_rest
      assign w_up_dist[g] = r_dist[g-1];
      assign w_up_idx[g]  = r_lidx[g-1];
    end
  end

  // List is ascending, so w_lt is a thermometer; its first set bit is the insert rank
  assign w_prev_lt = w_lt << 1;

  // Insertion: new entry at the first winning rank, worse ranks slide down by one
  always_comb begin
    for (int r = 0; r < K; r++) begin
      w_dist_nxt[r] = r_dist[r];
      w_lidx_nxt[r] = r_lidx[r];
      if (w_reinit) begin
        w_dist_nxt[r] = '1;
        w_lidx_nxt[r] = '0;
      end else if (w_ins && w_prev_lt[r]) begin
        w_dist_nxt[r] = w_up_dist[r];
        w_lidx_nxt[r] = w_up_idx[r];
      end else if (w_ins && w_lt[r]) begin
        w_dist_nxt[r] = r_s2_dist;
        w_lidx_nxt[r] = r_s2_idx;
      end else begin
        w_dist_nxt[r] = r_dist[r];
        w_lidx_nxt[r] = r_lidx[r];
      end
    end
  end

  // Sorted list storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < K; r++) begin
        r_dist[r] <= '1;
        r_lidx[r] <= '0;
      end
    end else begin
      for (int r = 0; r < K; r++) begin
        r_dist[r] <= w_dist_nxt[r];
        r_lidx[r] <= w_lidx_nxt[r];
      end
    end
  end

  // Rank select clamps to the last kept rank
  always_comb begin
    if (int'(knn.i_res_sel) >= K) begin
      w_rank = RANK_W'(K - 1);
    end else begin
      w_rank = knn.i_res_sel[RANK_W-1:0];
    end
  end

  assign knn.o_res_dist  = r_dist[w_rank];
  assign knn.o_res_idx   = r_lidx[w_rank];
  assign knn.o_knn_valid = r_valid;
endmodule
